mem_req_tracker: RTL and testbench
==================================

MEM_REQ_TRACKER -- requirements
Module: mem_req_tracker

Interface
REQ-001 SHALL have parameters: NUM_IDS, default 16, number of request IDs (power of 2); LINE_W, default 512, line data width.
REQ-002 SHALL have one clock and an asynchronous, active-low reset, with ports as below (clock and reset first).
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 req_valid / req_ready  in/out  1/1  cache-side request handshake; a request transfers when both are high.
REQ-006 req_write  in  1  1 = line write, 0 = line read.
REQ-007 req_addr / req_data  in  36/LINE_W  request byte address and write data.
REQ-008 addr_out / data_out  out  36/LINE_W  issued packet address and data toward mem_controller.
REQ-009 id_req_out / packet_type_req_out  out  4/3  issued ID and type: 000 none, 001 write, 011 read.
REQ-010 overwrite  in  1  response strobe from mem_controller.
REQ-011 id_req_in / packet_type_req_in  in  4/3  response ID and type: 101 write-ack, 110 read-data.
REQ-012 addr_in / data_in  in  36/LINE_W  response address and read data.
REQ-013 resp_valid / resp_write / resp_id  out  1/1/4  one-cycle retire pulse to the cache, its kind, and its ID.
REQ-014 resp_addr / resp_data  out  36/LINE_W  retired address and read data.
REQ-015 flush_req / flush_done  in/out  1/1  drain request and one-cycle completion pulse.
REQ-016 busy_cnt  out  5  outstanding count, 0..16.
REQ-017 err_resp  out  1  sticky flag for an illegal response.

Function
REQ-018 SHALL allocate IDs strictly in order 0..NUM_IDS-1 with wrap, using alloc_ptr, to match mem_controller's circular servicing.
REQ-019 req_ready SHALL be combinational: state==RUN & ~outstanding[alloc_ptr] & ~hazard.
REQ-020 hazard SHALL be 1 when req_addr[35:6] equals the line address of any outstanding write entry; this blocks both reads and writes.
REQ-021 On handshake, the block SHALL set, at the next edge: outstanding, the type bit, and the address for alloc_ptr; increment alloc_ptr; and register addr_out, data_out (zero for reads), id_req_out=alloc_ptr, and packet_type_req_out.
REQ-022 packet_type_req_out SHALL be 000 in every cycle without a new issue; issue latency is 1 cycle and throughput is 1 per cycle.
REQ-023 A response with overwrite=1 SHALL be legal only if outstanding[id_req_in] is set and the type matches: write↔101, read↔110.
REQ-024 A legal response SHALL, at the next edge, clear outstanding, pulse resp_valid, and register resp_write, resp_id, resp_addr (from the tracker entry), and resp_data (data_in for reads, zero for writes).
REQ-025 An illegal response SHALL set err_resp, leave tracker state unchanged, and produce no resp_valid.
REQ-026 A retired ID SHALL be re-allocatable starting the cycle after retirement.
REQ-027 Simultaneous issue and retire SHALL leave busy_cnt unchanged; busy_cnt SHALL never wrap.
REQ-028 FSM states SHALL be RUN, DRAIN, and DONE.
REQ-029 RUN→DRAIN on flush_req; requests are blocked in DRAIN.
REQ-030 DRAIN→DONE when busy_cnt==0, including the same cycle flush is seen.
REQ-031 In DONE, flush_done SHALL pulse for 1 cycle, then the FSM returns to RUN; flush_req in DRAIN or DONE is ignored.
REQ-032 Responses SHALL continue to be retired in every state.

Reset
REQ-033 While rst_n=0, the block SHALL be in state RUN with alloc_ptr=0, all outstanding=0, busy_cnt=0, all outputs 0 (packet_type_req_out=000), and err_resp=0.
REQ-034 Reset mid-operation SHALL discard all outstanding entries; responses arriving afterwards for discarded IDs are illegal per REQ-025.

Structure
REQ-035 A shared package mem_pkg SHALL hold the packet-type constants (001, 011, 101, 110, 000), the tracker-state enum, and the line-offset width (6).
REQ-036 A sub-module mem_id_table SHALL hold the per-ID valid, type, and address storage and the hazard compare; the FSM, counters, and output registers reside in the top module.

Verification
REQ-037 Single read: addr 0x0000_1040 → next cycle id 0, type 011. Response id 0, type 110, data 0xA5.. → resp_valid with id 0 and data 0xA5..
REQ-038 Fill: 16 back-to-back writes → IDs 0..15 issued, req_ready=0 at busy_cnt=16. Retire id 0 → the next request gets id 0 one cycle later.
REQ-039 Hazard: write to 0x40 outstanding, then read 0x7F → req_ready=0 until the 101 ack for that ID, then the read issues.
REQ-040 Illegal: response id 3 with nothing outstanding, and response type 110 for a write ID → err_resp=1, no resp_valid, busy_cnt unchanged.
REQ-041 Flush with 2 outstanding → requests blocked; after both retire, flush_done pulses once and state returns to RUN.
REQ-042 Reset with 5 outstanding → busy_cnt=0, alloc_ptr=0, next issue uses id 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory request tracker: packet type codes,
// tracker FSM states and line geometry.
package mem_pkg;

    localparam int ADDR_W      = 36;
    localparam int LINE_OFF_W  = 6;
    localparam int LINE_ADDR_W = ADDR_W - LINE_OFF_W;

    localparam logic [2:0] PKT_NONE  = 3'b000;
    localparam logic [2:0] PKT_WRITE = 3'b001;
    localparam logic [2:0] PKT_READ  = 3'b011;
    localparam logic [2:0] PKT_WACK  = 3'b101;
    localparam logic [2:0] PKT_RDATA = 3'b110;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } trk_state_e;

    // Cache-line address of a byte address (offset bits dropped).
    function automatic logic [LINE_ADDR_W-1:0] line_of(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1:LINE_OFF_W];
    endfunction

endpackage

// File: rtl/mem_id_table.sv
// Per-ID tracker storage: valid and write-type bits, the request address of
// each in-flight ID, and the read-after-write / write-after-write line hazard.
module mem_id_table
    import mem_pkg::*;
#(
    parameter int NUM_IDS = 16,
    parameter int ID_W    = $clog2(NUM_IDS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               alloc_en_i,
    input  logic [ID_W-1:0]    alloc_id_i,
    input  logic               alloc_write_i,
    input  logic [ADDR_W-1:0]  alloc_addr_i,
    input  logic               retire_en_i,
    input  logic [ID_W-1:0]    retire_id_i,
    input  logic [ADDR_W-1:0]  chk_addr_i,
    output logic               hazard_o,
    input  logic [ID_W-1:0]    query_id_i,
    output logic [ADDR_W-1:0]  query_addr_o,
    output logic [NUM_IDS-1:0] valid_o,
    output logic [NUM_IDS-1:0] write_o
);

    logic [NUM_IDS-1:0] valid_q, valid_d;
    logic [NUM_IDS-1:0] write_q, write_d;
    logic [ADDR_W-1:0]  addr_q [NUM_IDS];

    // Next-state of the valid/type bits; allocation and retirement never target the same ID.
    always_comb begin
        valid_d = valid_q;
        write_d = write_q;
        if (retire_en_i) begin
            valid_d[retire_id_i] = 1'b0;
        end
        if (alloc_en_i) begin
            valid_d[alloc_id_i] = 1'b1;
            write_d[alloc_id_i] = alloc_write_i;
        end
    end

    // Valid and type bits are cleared on reset so every discarded ID becomes free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            write_q <= '0;
        end else begin
            valid_q <= valid_d;
            write_q <= write_d;
        end
    end

    // Address storage needs no reset because it is only ever read behind a valid bit.
    always_ff @(posedge clk) begin
        if (alloc_en_i) begin
            addr_q[alloc_id_i] <= alloc_addr_i;
        end
    end

    // Any in-flight write to the same line blocks a new request of either kind.
    always_comb begin
        hazard_o = 1'b0;
        for (int i = 0; i < NUM_IDS; i++) begin
            if (valid_q[i] && write_q[i] && (line_of(addr_q[i]) == line_of(chk_addr_i))) begin
                hazard_o = 1'b1;
            end
        end
    end

    assign query_addr_o = addr_q[query_id_i];
    assign valid_o      = valid_q;
    assign write_o      = write_q;

endmodule

// File: rtl/mem_req_tracker.sv
// Memory request tracker: issues cache line requests toward the memory
// controller with in-order IDs, retires their responses, and supports a flush.
module mem_req_tracker
    import mem_pkg::*;
#(
    parameter int NUM_IDS = 16,
    parameter int LINE_W  = 512
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [35:0]       req_addr,
    input  logic [LINE_W-1:0] req_data,
    output logic [35:0]       addr_out,
    output logic [LINE_W-1:0] data_out,
    output logic [3:0]        id_req_out,
    output logic [2:0]        packet_type_req_out,
    input  logic              overwrite,
    input  logic [3:0]        id_req_in,
    input  logic [2:0]        packet_type_req_in,
    input  logic [35:0]       addr_in,
    input  logic [LINE_W-1:0] data_in,
    output logic              resp_valid,
    output logic              resp_write,
    output logic [3:0]        resp_id,
    output logic [35:0]       resp_addr,
    output logic [LINE_W-1:0] resp_data,
    input  logic              flush_req,
    output logic              flush_done,
    output logic [4:0]        busy_cnt,
    output logic              err_resp
);

    localparam int ID_W  = $clog2(NUM_IDS);
    localparam int CNT_W = ID_W + 1;

    trk_state_e         state_q;
    logic [ID_W-1:0]    alloc_ptr_q;
    logic [CNT_W-1:0]   busy_cnt_q, busy_cnt_d;
    logic [NUM_IDS-1:0] ent_valid, ent_write;
    logic [ID_W-1:0]    rsp_id;
    logic [35:0]        rsp_entry_addr;
    logic               hazard, issue, rsp_type_ok, rsp_legal, rsp_illegal;
    logic               addr_in_unused;

    // The echoed response address is not needed: the tracker entry is authoritative.
    assign addr_in_unused = ^addr_in;

    assign rsp_id      = id_req_in[ID_W-1:0];
    assign req_ready   = (state_q == ST_RUN) && !ent_valid[alloc_ptr_q] && !hazard;
    assign issue       = req_valid && req_ready;
    assign rsp_type_ok = ent_write[rsp_id] ? (packet_type_req_in == PKT_WACK)
                                           : (packet_type_req_in == PKT_RDATA);
    assign rsp_legal   = overwrite && ent_valid[rsp_id] && rsp_type_ok;
    assign rsp_illegal = overwrite && !rsp_legal;
    assign busy_cnt    = 5'(busy_cnt_q);

    mem_id_table #(
        .NUM_IDS (NUM_IDS)
    ) u_id_table (
        .clk           (clk),
        .rst_n         (rst_n),
        .alloc_en_i    (issue),
        .alloc_id_i    (alloc_ptr_q),
        .alloc_write_i (req_write),
        .alloc_addr_i  (req_addr),
        .retire_en_i   (rsp_legal),
        .retire_id_i   (rsp_id),
        .chk_addr_i    (req_addr),
        .hazard_o      (hazard),
        .query_id_i    (rsp_id),
        .query_addr_o  (rsp_entry_addr),
        .valid_o       (ent_valid),
        .write_o       (ent_write)
    );

    // Outstanding count: a simultaneous issue and retire cancel, and the count saturates both ways.
    always_comb begin
        busy_cnt_d = busy_cnt_q;
        if (issue && !rsp_legal && (busy_cnt_q != CNT_W'(NUM_IDS))) begin
            busy_cnt_d = busy_cnt_q + CNT_W'(1);
        end else if (!issue && rsp_legal && (busy_cnt_q != '0)) begin
            busy_cnt_d = busy_cnt_q - CNT_W'(1);
        end
    end

    // Allocation pointer walks IDs in order to match the controller's circular servicing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alloc_ptr_q <= '0;
            busy_cnt_q  <= '0;
        end else begin
            busy_cnt_q <= busy_cnt_d;
            if (issue) begin
                alloc_ptr_q <= alloc_ptr_q + ID_W'(1);
            end
        end
    end

    // Flush FSM: drain until nothing is outstanding, pulse flush_done for the DONE cycle, return to RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            flush_done <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (flush_req) begin
                        if ((busy_cnt_q == '0) && !issue) begin
                            state_q    <= ST_DONE;
                            flush_done <= 1'b1;
                        end else begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (busy_cnt_q == '0) begin
                        state_q    <= ST_DONE;
                        flush_done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_RUN;
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    // Issue packet registers; the type field reads as none in every cycle without an issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_out            <= '0;
            data_out            <= '0;
            id_req_out          <= '0;
            packet_type_req_out <= PKT_NONE;
        end else begin
            packet_type_req_out <= PKT_NONE;
            if (issue) begin
                addr_out            <= req_addr;
                data_out            <= req_write ? req_data : '0;
                id_req_out          <= 4'(alloc_ptr_q);
                packet_type_req_out <= req_write ? PKT_WRITE : PKT_READ;
            end
        end
    end

    // Retire registers and the sticky illegal-response flag; retirement runs in every FSM state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid <= 1'b0;
            resp_write <= 1'b0;
            resp_id    <= '0;
            resp_addr  <= '0;
            resp_data  <= '0;
            err_resp   <= 1'b0;
        end else begin
            resp_valid <= rsp_legal;
            if (rsp_illegal) begin
                err_resp <= 1'b1;
            end
            if (rsp_legal) begin
                resp_write <= ent_write[rsp_id];
                resp_id    <= id_req_in;
                resp_addr  <= rsp_entry_addr;
                resp_data  <= ent_write[rsp_id] ? '0 : data_in;
            end
        end
    end

endmodule

// File: tb/tb_mem_req_tracker.sv
// Testbench for mem_req_tracker: directed scenarios plus a randomized run,
// all checked against a behavioural model of the outstanding-ID table.
module tb_mem_req_tracker;

    localparam int LINE_W  = 512;
    localparam int NUM_IDS = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid, req_ready, req_write;
    logic [35:0]       req_addr;
    logic [LINE_W-1:0] req_data;
    logic [35:0]       addr_out;
    logic [LINE_W-1:0] data_out;
    logic [3:0]        id_req_out;
    logic [2:0]        packet_type_req_out;
    logic              overwrite;
    logic [3:0]        id_req_in;
    logic [2:0]        packet_type_req_in;
    logic [35:0]       addr_in;
    logic [LINE_W-1:0] data_in;
    logic              resp_valid, resp_write;
    logic [3:0]        resp_id;
    logic [35:0]       resp_addr;
    logic [LINE_W-1:0] resp_data;
    logic              flush_req, flush_done;
    logic [4:0]        busy_cnt;
    logic              err_resp;

    int total = 0;
    int bad   = 0;

    // Behavioural model: one entry per ID plus the allocation pointer and flush mode
    // (0 = accepting, 1 = draining, 2 = flush complete this cycle).
    bit          mOut [NUM_IDS];
    bit          mWr  [NUM_IDS];
    logic [35:0] mAd  [NUM_IDS];
    int          mPtr;
    int          mMode;
    bit          mErr;
    bit          lastFire;

    mem_req_tracker #(
        .NUM_IDS (NUM_IDS),
        .LINE_W  (LINE_W)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_write           (req_write),
        .req_addr            (req_addr),
        .req_data            (req_data),
        .addr_out            (addr_out),
        .data_out            (data_out),
        .id_req_out          (id_req_out),
        .packet_type_req_out (packet_type_req_out),
        .overwrite           (overwrite),
        .id_req_in           (id_req_in),
        .packet_type_req_in  (packet_type_req_in),
        .addr_in             (addr_in),
        .data_in             (data_in),
        .resp_valid          (resp_valid),
        .resp_write          (resp_write),
        .resp_id             (resp_id),
        .resp_addr           (resp_addr),
        .resp_data           (resp_data),
        .flush_req           (flush_req),
        .flush_done          (flush_done),
        .busy_cnt            (busy_cnt),
        .err_resp            (err_resp)
    );

    // Free-running 10-time-unit clock.
    always #5 clk = ~clk;

    // Hard stop in case the run stalls.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [LINE_W-1:0] randLine();
        logic [LINE_W-1:0] r;
        for (int i = 0; i < LINE_W / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    function automatic int modelCount();
        int n = 0;
        for (int i = 0; i < NUM_IDS; i++) n += int'(mOut[i]);
        return n;
    endfunction

    function automatic bit modelReady(input logic [35:0] a);
        if (mMode != 0 || mOut[mPtr]) return 1'b0;
        for (int i = 0; i < NUM_IDS; i++)
            if (mOut[i] && mWr[i] && (mAd[i] >> 6) == (a >> 6)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic clearModel();
        for (int i = 0; i < NUM_IDS; i++) begin
            mOut[i] = 1'b0;
            mWr[i]  = 1'b0;
            mAd[i]  = '0;
        end
        mPtr  = 0;
        mMode = 0;
        mErr  = 1'b0;
    endtask

    task automatic driveIdle();
        req_valid          = 1'b0;
        req_write          = 1'b0;
        req_addr           = '0;
        req_data           = '0;
        overwrite          = 1'b0;
        id_req_in          = '0;
        packet_type_req_in = '0;
        addr_in            = '0;
        data_in            = '0;
        flush_req          = 1'b0;
    endtask

    // One clock cycle: drive inputs, check ready, let the edge happen, check every output.
    task automatic applyStimulus(input bit v, input bit w, input logic [35:0] a, input logic [LINE_W-1:0] d,
                                 input bit ov, input int rid, input logic [2:0] rty,
                                 input logic [LINE_W-1:0] rd, input bit fl);
        bit expReady, fire, legal;
        int cntNow, nextMode;
        @(negedge clk);
        req_valid          = v;
        req_write          = w;
        req_addr           = a;
        req_data           = d;
        overwrite          = ov;
        id_req_in          = rid[3:0];
        packet_type_req_in = rty;
        addr_in            = ov ? mAd[rid] : '0;
        data_in            = rd;
        flush_req          = fl;
        #1;
        expReady = modelReady(a);
        checkOutput("req_ready", req_ready, expReady);
        fire   = v && expReady;
        legal  = ov && mOut[rid] && (mWr[rid] ? (rty == 3'b101) : (rty == 3'b110));
        cntNow = modelCount();
        case (mMode)
            0:       nextMode = fl ? ((cntNow == 0 && !fire) ? 2 : 1) : 0;
            1:       nextMode = (cntNow == 0) ? 2 : 1;
            default: nextMode = 0;
        endcase
        @(posedge clk);
        #1;
        checkOutput("pkt_type", packet_type_req_out, fire ? (w ? 3'b001 : 3'b011) : 3'b000);
        if (fire) begin
            checkOutput("issue_id", id_req_out, mPtr);
            checkOutput("issue_addr", addr_out, a);
            checkOutput("issue_data", data_out, w ? d : '0);
        end
        checkOutput("resp_valid", resp_valid, legal);
        if (legal) begin
            checkOutput("resp_write", resp_write, mWr[rid]);
            checkOutput("resp_id", resp_id, rid);
            checkOutput("resp_addr", resp_addr, mAd[rid]);
            checkOutput("resp_data", resp_data, mWr[rid] ? '0 : rd);
        end
        if (legal) mOut[rid] = 1'b0;
        if (ov && !legal) mErr = 1'b1;
        if (fire) begin
            mOut[mPtr] = 1'b1;
            mWr[mPtr]  = w;
            mAd[mPtr]  = a;
            mPtr       = (mPtr + 1) % NUM_IDS;
        end
        mMode = nextMode;
        checkOutput("err_resp", err_resp, mErr);
        checkOutput("busy_cnt", busy_cnt, modelCount());
        checkOutput("flush_done", flush_done, mMode == 2);
        lastFire = fire;
    endtask

    task automatic doReq(input bit w, input logic [35:0] a);
        applyStimulus(1'b1, w, a, randLine(), 1'b0, 0, 3'b000, '0, 1'b0);
    endtask

    task automatic doResp(input int rid, input logic [2:0] rty, input logic [LINE_W-1:0] rd);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, rid, rty, rd, 1'b0);
    endtask

    task automatic doIdle();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 0, 3'b000, '0, 1'b0);
    endtask

    // Reset across one rising edge, checking that outputs read zero while it is held.
    task automatic resetDut();
        @(negedge clk);
        driveIdle();
        rst_n = 1'b0;
        clearModel();
        #1;
        checkOutput("rst_busy", busy_cnt, 5'd0);
        checkOutput("rst_pkt", packet_type_req_out, 3'b000);
        checkOutput("rst_resp_valid", resp_valid, 1'b0);
        checkOutput("rst_err", err_resp, 1'b0);
        checkOutput("rst_flush_done", flush_done, 1'b0);
        checkOutput("rst_id_out", id_req_out, 4'd0);
        @(posedge clk);
        #1;
        checkOutput("rst_busy_edge", busy_cnt, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int pulses;
        logic [LINE_W-1:0] a5Line;
        rst_n = 1'b1;
        driveIdle();
        clearModel();
        resetDut();

        // Single read followed by its read-data response.
        a5Line = {(LINE_W/8){8'hA5}};
        doReq(1'b0, 36'h0_0000_1040);
        checkOutput("single_id", id_req_out, 4'd0);
        checkOutput("single_type", packet_type_req_out, 3'b011);
        doResp(0, 3'b110, a5Line);
        checkOutput("single_resp_valid", resp_valid, 1'b1);
        checkOutput("single_resp_data", resp_data, a5Line);

        // Fill all IDs with writes, confirm blocking, retire ID 0 and reuse it.
        resetDut();
        for (int i = 0; i < NUM_IDS; i++) doReq(1'b1, 36'h1_0000 + 36'(i * 64));
        checkOutput("fill_cnt", busy_cnt, 5'd16);
        doReq(1'b1, 36'h2_0000);
        checkOutput("fill_blocked", packet_type_req_out, 3'b000);
        doResp(0, 3'b101, '0);
        doReq(1'b1, 36'h2_0000);
        checkOutput("refill_id", id_req_out, 4'd0);
        checkOutput("refill_type", packet_type_req_out, 3'b001);

        // Line hazard: a read to the same line waits for the write ack.
        resetDut();
        doReq(1'b1, 36'h40);
        for (int i = 0; i < 3; i++) begin
            doReq(1'b0, 36'h7F);
            checkOutput("haz_blocked", packet_type_req_out, 3'b000);
        end
        applyStimulus(1'b1, 1'b0, 36'h7F, '0, 1'b1, 0, 3'b101, '0, 1'b0);
        checkOutput("haz_ack", resp_valid, 1'b1);
        doReq(1'b0, 36'h7F);
        checkOutput("haz_issue", packet_type_req_out, 3'b011);
        checkOutput("haz_issue_id", id_req_out, 4'd1);

        // Illegal responses: nothing outstanding, then the wrong type for a write ID.
        resetDut();
        doResp(3, 3'b101, '0);
        checkOutput("ill_none_err", err_resp, 1'b1);
        checkOutput("ill_none_busy", busy_cnt, 5'd0);
        resetDut();
        doReq(1'b1, 36'h80);
        doResp(0, 3'b110, randLine());
        checkOutput("ill_type_err", err_resp, 1'b1);
        checkOutput("ill_type_valid", resp_valid, 1'b0);
        checkOutput("ill_type_busy", busy_cnt, 5'd1);

        // Flush with two outstanding writes.
        resetDut();
        doReq(1'b1, 36'h1000);
        doReq(1'b1, 36'h2000);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 0, 3'b000, '0, 1'b1);
        doReq(1'b0, 36'h3000);
        checkOutput("flush_blocked", packet_type_req_out, 3'b000);
        doResp(0, 3'b101, '0);
        doResp(1, 3'b101, '0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            doIdle();
            if (flush_done) pulses++;
        end
        checkOutput("flush_pulses", pulses, 1);
        doReq(1'b0, 36'h3000);
        checkOutput("flush_resume", packet_type_req_out, 3'b011);

        // Reset with five outstanding discards them and restarts at ID 0.
        resetDut();
        for (int i = 0; i < 5; i++) doReq(1'b1, 36'h4000 + 36'(i * 64));
        checkOutput("pre_rst_busy", busy_cnt, 5'd5);
        resetDut();
        doResp(2, 3'b101, '0);
        checkOutput("post_rst_stale", err_resp, 1'b1);
        doReq(1'b0, 36'h9000);
        checkOutput("post_rst_id", id_req_out, 4'd0);

        // Randomized traffic over a handful of lines to provoke hazards and wrap.
        resetDut();
        for (int cyc = 0; cyc < 800; cyc++) begin
            bit v, w, ov, fl;
            int rid;
            logic [2:0] rty;
            logic [35:0] a;
            int q[$];
            v   = ($urandom_range(0, 99) < 60);
            w   = $urandom_range(0, 1);
            a   = 36'($urandom_range(0, 7) * 64 + $urandom_range(0, 63));
            fl  = ($urandom_range(0, 99) < 2);
            ov  = 1'b0;
            rid = 0;
            rty = 3'b000;
            for (int i = 0; i < NUM_IDS; i++) if (mOut[i]) q.push_back(i);
            if (q.size() > 0 && $urandom_range(0, 99) < 45) begin
                ov  = 1'b1;
                rid = q[$urandom_range(0, q.size() - 1)];
                rty = mWr[rid] ? 3'b101 : 3'b110;
                if ($urandom_range(0, 99) < 3) rty = mWr[rid] ? 3'b110 : 3'b101;
            end else if ($urandom_range(0, 99) < 2) begin
                ov  = 1'b1;
                rid = $urandom_range(0, NUM_IDS - 1);
                rty = $urandom_range(0, 1) ? 3'b101 : 3'b110;
            end
            applyStimulus(v, w, a, randLine(), ov, rid, rty, randLine(), fl);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
